// File: rtl/fb_pkg.sv
// Shared constants, protocol byte codes and FSM state encoding for the
// UART-driven framebuffer write controller.
package fb_pkg;

  // Protocol framing byte and command codes
  localparam logic [7:0] SYNC_BYTE    = 8'hA5;
  localparam logic [7:0] CMD_SET_ADDR = 8'h01;
  localparam logic [7:0] CMD_STREAM   = 8'h02;
  localparam logic [7:0] CMD_FILL     = 8'h03;

  // Default display geometry
  localparam int DEF_H_RES = 640;
  localparam int DEF_V_RES = 480;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR2,
    ST_ADDR1,
    ST_ADDR0,
    ST_STREAM,
    ST_FILL_VAL,
    ST_FILL
  } state_t;

  // States that are waiting on the host and therefore subject to the
  // inter-byte timeout. IDLE waits forever; FILL runs without host bytes.
  function automatic logic is_timed(input state_t s);
    logic timed;
    case (s)
      ST_CMD, ST_ADDR2, ST_ADDR1, ST_ADDR0, ST_STREAM, ST_FILL_VAL: timed = 1'b1;
      default:                                                      timed = 1'b0;
    endcase
    return timed;
  endfunction

endpackage

// File: rtl/fb_cmd_decoder.sv
// Byte-protocol FSM: parses sync/command/address/pixel bytes from the UART
// and emits per-cycle strobes (pixel write, fill write, address load,
// protocol error) for the write controller to act on.
module fb_cmd_decoder
  import fb_pkg::*;
#(
  parameter int FB_PIXELS   = DEF_H_RES * DEF_V_RES,
  parameter int ADDR_W      = $clog2(FB_PIXELS),
  parameter int PIX_W       = 8,
  parameter int TIMEOUT_CYC = 5_000_000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic              at_last,
  output logic              pix_stb,
  output logic              fill_stb,
  output logic [PIX_W-1:0]  pix_data,
  output logic              addr_load,
  output logic [ADDR_W-1:0] addr_val,
  output logic              err_stb,
  output logic              busy
);

  localparam int              TMO_W       = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_LAST   = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [31:0]      FB_PIXELS_U = 32'(FB_PIXELS);

  state_t            state_q, state_d;
  logic [15:0]       addr_hi_q, addr_hi_d;
  logic [PIX_W-1:0]  fill_q, fill_d;
  logic [TMO_W-1:0]  cnt_q, cnt_d;
  logic [23:0]       addr_full;

  // State, collected address bytes, fill value and timeout counter registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      addr_hi_q <= '0;
      fill_q    <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      addr_hi_q <= addr_hi_d;
      fill_q    <= fill_d;
      cnt_q     <= cnt_d;
    end
  end

  // Next-state and strobe decode; the timeout override is applied last so it
  // wins only in cycles without a byte
  always_comb begin
    state_d   = state_q;
    addr_hi_d = addr_hi_q;
    fill_d    = fill_q;
    cnt_d     = cnt_q;
    pix_stb   = 1'b0;
    fill_stb  = 1'b0;
    addr_load = 1'b0;
    err_stb   = 1'b0;
    pix_data  = fill_q;
    addr_full = {addr_hi_q, rx_data};
    addr_val  = ADDR_W'(addr_full);

    case (state_q)
      ST_IDLE: begin
        if (rx_valid) begin
          if (rx_data == SYNC_BYTE) state_d = ST_CMD;
          else                      err_stb = 1'b1;
        end
      end
      ST_CMD: begin
        if (rx_valid) begin
          case (rx_data)
            CMD_SET_ADDR: state_d = ST_ADDR2;
            CMD_STREAM:   state_d = ST_STREAM;
            CMD_FILL:     state_d = ST_FILL_VAL;
            default: begin
              err_stb = 1'b1;
              state_d = ST_IDLE;
            end
          endcase
        end
      end
      ST_ADDR2: begin
        if (rx_valid) begin
          addr_hi_d[15:8] = rx_data;
          state_d         = ST_ADDR1;
        end
      end
      ST_ADDR1: begin
        if (rx_valid) begin
          addr_hi_d[7:0] = rx_data;
          state_d        = ST_ADDR0;
        end
      end
      ST_ADDR0: begin
        if (rx_valid) begin
          if ({8'h00, addr_full} < FB_PIXELS_U) addr_load = 1'b1;
          else                                  err_stb   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_STREAM: begin
        if (rx_valid) begin
          pix_stb  = 1'b1;
          pix_data = PIX_W'(rx_data);
          if (at_last) state_d = ST_IDLE;
        end
      end
      ST_FILL_VAL: begin
        if (rx_valid) begin
          fill_d  = PIX_W'(rx_data);
          state_d = ST_FILL;
        end
      end
      ST_FILL: begin
        fill_stb = 1'b1;
        if (rx_valid) err_stb = 1'b1;
        if (at_last)  state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (is_timed(state_q) && !rx_valid && (cnt_q == TMO_LAST)) begin
      err_stb = 1'b1;
      state_d = ST_IDLE;
    end

    if ((state_d != state_q) || rx_valid || !is_timed(state_q)) cnt_d = '0;
    else                                                         cnt_d = cnt_q + TMO_W'(1);
  end

  assign busy = (state_q != ST_IDLE);

endmodule

// File: rtl/fb_write_ctrl.sv
// Framebuffer write controller: owns the protocol write pointer and the
// registered BRAM write port, arbitrating between protocol writes (which
// can never stall) and a held cursor write request.
module fb_write_ctrl
  import fb_pkg::*;
#(
  parameter  int H_RES       = DEF_H_RES,
  parameter  int V_RES       = DEF_V_RES,
  parameter  int PIX_W       = 8,
  parameter  int TIMEOUT_CYC = 5_000_000,
  localparam int FB_PIXELS   = H_RES * V_RES,
  localparam int ADDR_W      = $clog2(FB_PIXELS)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic              cur_req,
  input  logic [ADDR_W-1:0] cur_addr,
  input  logic [PIX_W-1:0]  cur_data,
  output logic              cur_ack,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [PIX_W-1:0]  wr_data,
  output logic              frame_done,
  output logic              proto_err,
  output logic              busy,
  output logic [ADDR_W-1:0] wr_ptr
);

  localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(FB_PIXELS - 1);
  localparam logic [31:0]       FB_PIXELS_U = 32'(FB_PIXELS);

  logic              pix_stb, fill_stb, addr_load, err_stb, at_last, cur_ok;
  logic [PIX_W-1:0]  pix_data;
  logic [ADDR_W-1:0] addr_val;

  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [PIX_W-1:0]  wr_data_q, wr_data_d;
  logic              cur_ack_q, cur_ack_d;
  logic              frame_done_q, frame_done_d;
  logic              proto_err_q, proto_err_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;

  assign at_last = (wr_ptr_q == LAST_ADDR);
  assign cur_ok  = ({{(32-ADDR_W){1'b0}}, cur_addr} < FB_PIXELS_U);

  fb_cmd_decoder #(
    .FB_PIXELS  (FB_PIXELS),
    .ADDR_W     (ADDR_W),
    .PIX_W      (PIX_W),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_dec (
    .clk      (clk),
    .reset_n  (reset_n),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .at_last  (at_last),
    .pix_stb  (pix_stb),
    .fill_stb (fill_stb),
    .pix_data (pix_data),
    .addr_load(addr_load),
    .addr_val (addr_val),
    .err_stb  (err_stb),
    .busy     (busy)
  );

  // Output port and write pointer registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      cur_ack_q    <= 1'b0;
      frame_done_q <= 1'b0;
      proto_err_q  <= 1'b0;
      wr_ptr_q     <= '0;
    end else begin
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      cur_ack_q    <= cur_ack_d;
      frame_done_q <= frame_done_d;
      proto_err_q  <= proto_err_d;
      wr_ptr_q     <= wr_ptr_d;
    end
  end

  // Arbitration: protocol writes first, cursor only in an otherwise free
  // cycle and never in the cycle its previous ack is showing, so a request
  // still held during the ack is not written twice. An out-of-range cursor
  // address is acknowledged but not written, so the requester cannot hang.
  always_comb begin
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    cur_ack_d    = 1'b0;
    frame_done_d = 1'b0;
    proto_err_d  = err_stb;
    wr_ptr_d     = wr_ptr_q;

    if (pix_stb || fill_stb) begin
      wr_en_d   = 1'b1;
      wr_addr_d = wr_ptr_q;
      wr_data_d = pix_data;
      if (at_last) begin
        wr_ptr_d     = '0;
        frame_done_d = 1'b1;
      end else begin
        wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      end
    end else begin
      if (addr_load) wr_ptr_d = addr_val;
      if (cur_req && !cur_ack_q) begin
        cur_ack_d = 1'b1;
        if (cur_ok) begin
          wr_en_d   = 1'b1;
          wr_addr_d = cur_addr;
          wr_data_d = cur_data;
        end
      end
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign cur_ack    = cur_ack_q;
  assign frame_done = frame_done_q;
  assign proto_err  = proto_err_q;
  assign wr_ptr     = wr_ptr_q;

endmodule

// File: tb/tb_fb_write_ctrl.sv
// Directed bench for fb_write_ctrl on a 16x8 frame (128 pixels, 7-bit
// addresses) with a 100-cycle inter-byte timeout.
module tb_fb_write_ctrl;

  localparam int AW = 7;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          cur_req;
  logic [AW-1:0] cur_addr;
  logic [7:0]    cur_data;
  logic          cur_ack, wr_en, frame_done, proto_err, busy;
  logic [AW-1:0] wr_addr, wr_ptr;
  logic [7:0]    wr_data;

  int checks = 0;
  int errors = 0;

  // Running event counters sampled on the falling edge
  int wr_total   = 0;
  int cur100_wrs = 0;
  int err_pulses = 0;

  fb_write_ctrl #(
    .H_RES(16), .V_RES(8), .PIX_W(8), .TIMEOUT_CYC(100)
  ) dut (
    .clk(clk), .reset_n(reset_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .cur_req(cur_req), .cur_addr(cur_addr), .cur_data(cur_data),
    .cur_ack(cur_ack), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .frame_done(frame_done), .proto_err(proto_err), .busy(busy),
    .wr_ptr(wr_ptr)
  );

  always #5 clk = ~clk;

  // Event monitor
  always @(negedge clk) begin
    if (wr_en) wr_total <= wr_total + 1;
    if (wr_en && wr_addr == 7'd100) cur100_wrs <= cur100_wrs + 1;
    if (proto_err) err_pulses <= err_pulses + 1;
  end

  // Watchdog so the bench can never hang
  initial begin
    #400000;
    $display("[TB] FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "[TB] watchdog");
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one byte for exactly one rising edge; returns on the next falling edge
  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  // Count cycles until proto_err appears, bounded
  task automatic wait_timeout(input string tag);
    int n = 0;
    while (!proto_err && n < 300) begin
      @(negedge clk);
      n++;
    end
    check_output(tag, n, 100);
  endtask

  initial begin
    int snap_wr, snap_err, snap_cur;
    int n, good, ea, fd_at, ack_at;

    reset_n = 1'b0; rx_data = 8'h00; rx_valid = 1'b0;
    cur_req = 1'b0; cur_addr = '0; cur_data = 8'h00;

    // Reset state
    repeat (3) @(negedge clk);
    check_output("rst_wr_en", wr_en, 0);
    check_output("rst_busy", busy, 0);
    check_output("rst_wr_ptr", wr_ptr, 0);
    check_output("rst_cur_ack", cur_ack, 0);
    check_output("rst_flags", {frame_done, proto_err}, 0);
    reset_n = 1'b1;

    // Address load then two streamed pixels
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00); send_byte(8'h00); send_byte(8'h10);
    check_output("load16_ptr", wr_ptr, 16);
    check_output("load16_idle", busy, 0);
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h11);
    check_output("s1_wr", {wr_en, 1'b0, wr_addr, wr_data}, {1'b1, 1'b0, 7'd16, 8'h11});
    send_byte(8'h22);
    check_output("s2_wr", {wr_en, 1'b0, wr_addr, wr_data}, {1'b1, 1'b0, 7'd17, 8'h22});
    check_output("s2_ptr", wr_ptr, 18);
    check_output("s2_busy", busy, 1);
    wait_timeout("stream_timeout_cycles");
    check_output("stream_timeout_idle", busy, 0);

    // Last pixel of the frame
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00); send_byte(8'h00); send_byte(8'h7F);
    check_output("load127_ptr", wr_ptr, 127);
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h7E);
    check_output("last_wr", {wr_en, 1'b0, wr_addr, wr_data}, {1'b1, 1'b0, 7'd127, 8'h7E});
    check_output("last_frame_done", frame_done, 1);
    check_output("last_wrap", wr_ptr, 0);
    check_output("last_idle", busy, 0);
    @(negedge clk);
    check_output("last_fd_pulse", {frame_done, wr_en}, 0);

    // Cursor request colliding with a stream byte
    send_byte(8'hA5); send_byte(8'h02);
    #1 snap_cur = cur100_wrs;
    cur_addr = 7'd100; cur_data = 8'hE0; cur_req = 1'b1;
    send_byte(8'h33);
    check_output("coll_rx_first", {wr_en, cur_ack, wr_addr, wr_data}, {1'b1, 1'b0, 7'd0, 8'h33});
    @(negedge clk);
    check_output("coll_cur_next", {wr_en, cur_ack, wr_addr, wr_data}, {1'b1, 1'b1, 7'd100, 8'hE0});
    check_output("coll_ptr", wr_ptr, 1);
    @(negedge clk);
    check_output("coll_no_rewrite", {wr_en, cur_ack}, 0);
    cur_req = 1'b0;
    @(negedge clk);
    #1 check_output("coll_cur_count", cur100_wrs - snap_cur, 1);

    // Reset in the middle of a stream
    send_byte(8'h44);
    check_output("pre_rst_wr", {wr_en, wr_addr}, {1'b1, 7'd1});
    reset_n = 1'b0;
    #1;
    check_output("async_rst_out", {wr_en, wr_addr, wr_data, busy, wr_ptr}, 0);
    snap_wr = wr_total;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    #1 snap_err = err_pulses;
    send_byte(8'h55);
    @(negedge clk);
    #1;
    check_output("post_rst_no_wr", wr_total - snap_wr, 0);
    check_output("post_rst_err", err_pulses - snap_err, 1);

    // Protocol errors leave the pointer alone
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00); send_byte(8'h00); send_byte(8'h05);
    check_output("load5_ptr", wr_ptr, 5);
    #1 begin snap_err = err_pulses; snap_wr = wr_total; end
    send_byte(8'h55);
    send_byte(8'hA5); send_byte(8'h09);
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h05); send_byte(8'h00); send_byte(8'h00);
    @(negedge clk);
    #1;
    check_output("perr_count", err_pulses - snap_err, 3);
    check_output("perr_no_wr", wr_total - snap_wr, 0);
    check_output("perr_ptr", wr_ptr, 5);

    // Stall inside the address phase
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
    check_output("addr1_busy", busy, 1);
    wait_timeout("addr1_timeout_cycles");
    check_output("addr1_timeout_idle", {busy, wr_ptr}, {1'b0, 7'd5});

    // Full-frame fill with a cursor request and a stray byte mid-fill
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    check_output("load0_ptr", wr_ptr, 0);
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h3C);
    #1 snap_err = err_pulses;
    n = 0; good = 0; ea = 0; fd_at = -1; ack_at = -1;
    while (n < 400 && ack_at < 0) begin
      if (n == 20) begin cur_addr = 7'd50; cur_data = 8'hAA; cur_req = 1'b1; end
      if (n == 40) begin rx_data = 8'h99; rx_valid = 1'b1; end
      if (n == 41) rx_valid = 1'b0;
      @(negedge clk);
      n++;
      if (wr_en && !cur_ack && int'(wr_addr) == ea && wr_data == 8'h3C) begin
        good++;
        ea++;
      end
      if (frame_done) fd_at = n;
      if (cur_ack) ack_at = n;
    end
    check_output("fill_writes", good, 128);
    check_output("fill_frame_done_at", fd_at, 128);
    check_output("fill_cur_ack_at", ack_at, 129);
    check_output("fill_cur_wr", {wr_en, wr_addr, wr_data}, {1'b1, 7'd50, 8'hAA});
    check_output("fill_end_state", {busy, wr_ptr}, 0);
    @(negedge clk);
    check_output("fill_cur_single", {cur_ack, wr_en}, 0);
    cur_req = 1'b0;
    #1 check_output("fill_stray_err", err_pulses - snap_err, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fb_write_ctrl.md
FB_WRITE_CTRL -- requirements
Module: fb_write_ctrl

Interface
REQ-001 SHALL have parameters: H_RES, default 640, pixels per line; V_RES, default 480, lines per frame; PIX_W, default 8, pixel width; TIMEOUT_CYC, default 5_000_000, inter-byte timeout in clk cycles (100 ms at 50 MHz).
REQ-002 SHALL derive local constants FB_PIXELS = H_RES*V_RES and ADDR_W = clog2(FB_PIXELS), which is 19 at defaults.
REQ-003 SHALL have port clk, input, 1: single system clock, 50 MHz.
REQ-004 SHALL have port reset_n, input, 1: asynchronous active-low reset.
REQ-005 SHALL have port rx_data, input, 8: received UART byte.
REQ-006 SHALL have port rx_valid, input, 1: one-cycle strobe qualifying rx_data.
REQ-007 SHALL have ports cur_req (input, 1), cur_addr (input, ADDR_W) and cur_data (input, PIX_W): cursor write request, held until acknowledged.
REQ-008 SHALL have port cur_ack, output, 1: one-cycle pulse marking the cycle the cursor write is issued.
REQ-009 SHALL have ports wr_en (output, 1), wr_addr (output, ADDR_W) and wr_data (output, PIX_W): framebuffer BRAM write port, all registered.
REQ-010 SHALL have ports frame_done (output, 1) and proto_err (output, 1): one-cycle status pulses.
REQ-011 SHALL have ports busy (output, 1), high whenever state is not IDLE, and wr_ptr (output, ADDR_W), the current protocol write address.

Function
REQ-012 SHALL implement the states IDLE, CMD, ADDR2, ADDR1, ADDR0, STREAM, FILL_VAL and FILL.
REQ-013 In IDLE, on byte 0xA5, SHALL go to CMD; on any other byte SHALL pulse proto_err and stay in IDLE.
REQ-014 In CMD, SHALL dispatch 0x01 to ADDR2, 0x02 to STREAM and 0x03 to FILL_VAL; any other byte SHALL pulse proto_err and return to IDLE.
REQ-015 In ADDR2, ADDR1 and ADDR0, SHALL collect a 24-bit big-endian address; after ADDR0, if the value is below FB_PIXELS it SHALL load wr_ptr from the low ADDR_W bits, otherwise it SHALL pulse proto_err and leave wr_ptr unchanged; it SHALL return to IDLE in both cases.
REQ-016 In STREAM, each byte SHALL produce a write of wr_data = byte[PIX_W-1:0] at address wr_ptr, with wr_en asserted exactly one cycle after rx_valid, and wr_ptr SHALL then increment.
REQ-017 In FILL_VAL, SHALL latch the received byte as the fill value and then go to FILL.
REQ-018 In FILL, SHALL write the fill value at wr_ptr on every cycle, incrementing wr_ptr, with no rx_valid needed.
REQ-019 SHALL treat a write at address FB_PIXELS-1 (STREAM or FILL) as end of frame: pulse frame_done in the same cycle as that wr_en, wrap wr_ptr to 0 and go to IDLE.
REQ-020 In FILL, bytes arriving on rx_valid SHALL be discarded and SHALL each pulse proto_err.
REQ-021 In CMD, ADDR2, ADDR1, ADDR0, FILL_VAL and STREAM, a gap of TIMEOUT_CYC cycles with no rx_valid SHALL pulse proto_err and return to IDLE; the timeout counter SHALL reload on every rx_valid and on every state entry.
REQ-022 Arbitration: a protocol write (STREAM byte or FILL cycle) SHALL always win, because UART bytes cannot be stalled.
REQ-023 A cursor grant SHALL occur in a cycle where cur_req=1, no protocol write is issued, and cur_ack is currently 0; the grant SHALL produce wr_en, wr_addr = cur_addr, wr_data = cur_data and cur_ack, all in the next cycle.
REQ-024 The cur_ack=0 condition in REQ-023 SHALL prevent a double write from a request still held high in the acknowledge cycle.
REQ-025 If rx_valid and cur_req occur in the same cycle, the rx byte SHALL be serviced and the cursor request SHALL remain pending with no loss.
REQ-026 Cursor writes SHALL NOT alter wr_ptr.
REQ-027 The cursor MAY be starved for the duration of FILL, up to FB_PIXELS cycles.
REQ-028 wr_en SHALL never be asserted for an address of FB_PIXELS or above.

Reset
REQ-029 On reset_n=0, SHALL asynchronously force state to IDLE, wr_ptr to 0, the timeout counter and fill value to 0, and all outputs to 0.
REQ-030 Reset during STREAM or FILL SHALL abort the operation with no further writes; after release, the next write SHALL require a fresh 0xA5 sequence.

Structure
REQ-031 A shared package fb_pkg SHALL hold SYNC_BYTE=0xA5, the command codes 0x01, 0x02 and 0x03, the state enumeration, and the default H_RES and V_RES.
REQ-032 The byte protocol FSM SHALL be a sub-module, fb_cmd_decoder, emitting pixel strobes, address-load and fill-start signals.
REQ-033 Arbitration, wr_ptr and output registers SHALL remain in fb_write_ctrl.

Verification
REQ-034 Bytes A5 01 00 01 00 then A5 02 11 22 -> writes 0x11@256 and 0x22@257; wr_ptr=258; busy=1 until timeout.
REQ-035 A5 01 04 AF FF (=307199) then A5 02 7E -> write 0x7E@307199, frame_done coincident, wr_ptr=0, state IDLE.
REQ-036 A5 03 3C from wr_ptr=0 -> 307200 consecutive writes of 0x3C, frame_done on the last; a cur_req raised mid-fill acks exactly one cycle after the fill ends.
REQ-037 cur_req held with cur_addr=1000, cur_data=0xE0 while rx_valid coincides -> rx write first, cursor write next cycle with cur_ack; exactly one cursor write.
REQ-038 Bytes 0x55, then A5 09, then A5 01 05 00 00 -> three proto_err pulses, wr_ptr unchanged, no wr_en.
REQ-039 reset_n low for 3 cycles mid-STREAM (TIMEOUT_CYC=100) -> outputs 0 immediately, no writes after; stall 100 cycles in ADDR1 -> proto_err and IDLE.
